// File: rtl/regfile_wb_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | regfile_wb_arbiter_if : writeback, reservation and hazard-check signals  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface regfile_wb_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
);
  localparam int c_IDXW = $clog2(NREG);

  logic              rsv_valid;
  logic [c_IDXW-1:0] rsv_dest;
  logic              rsv_ready;

  logic              a_valid;
  logic [c_IDXW-1:0] a_dest;
  logic [WIDTH-1:0]  a_data;
  logic              a_ready;

  logic              b_valid;
  logic [c_IDXW-1:0] b_dest;
  logic [WIDTH-1:0]  b_data;
  logic              b_ready;

  logic              rf_load;
  logic [c_IDXW-1:0] rf_dest;
  logic [WIDTH-1:0]  rf_data;

  logic [c_IDXW-1:0] chk_src_a;
  logic [c_IDXW-1:0] chk_src_b;
  logic              chk_busy_a;
  logic              chk_busy_b;

  logic [NREG-1:0]   pending;
  logic              err;

  modport slave (
    input  rsv_valid, rsv_dest, a_valid, a_dest, a_data, b_valid, b_dest, b_data,
           chk_src_a, chk_src_b,
    output rsv_ready, a_ready, b_ready, rf_load, rf_dest, rf_data,
           chk_busy_a, chk_busy_b, pending, err
  );

  modport master (
    output rsv_valid, rsv_dest, a_valid, a_dest, a_data, b_valid, b_dest, b_data,
           chk_src_a, chk_src_b,
    input  rsv_ready, a_ready, b_ready, rf_load, rf_dest, rf_data,
           chk_busy_a, chk_busy_b, pending, err
  );
endinterface

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// +--------------------------------------------------------------------------+
// | regfile_wb_arbiter : round-robin regfile write-port arbiter + scoreboard |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module regfile_wb_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
) (
  input wire logic              clk,
  input wire logic              rst_n,
  regfile_wb_arbiter_if.slave   wb
);
  localparam int c_IDXW = $clog2(NREG);

  typedef enum logic [0:0] {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  prio_e             prio_q, prio_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic              rf_load_q;
  logic [c_IDXW-1:0] rf_dest_q;
  logic [WIDTH-1:0]  rf_data_q;
  logic              err_q;

  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_wr_xfer;
  logic              w_rsv_ready;
  logic              w_rsv_xfer;
  logic [c_IDXW-1:0] w_wr_dest;
  logic [WIDTH-1:0]  w_wr_data;
  logic [NREG-1:0]   w_set;
  logic [NREG-1:0]   w_clr;
  logic              w_unreserved;

  always_comb begin
    w_grant_a    = wb.a_valid && (!wb.b_valid || (prio_q == PRIO_A));
    w_grant_b    = wb.b_valid && (!wb.a_valid || (prio_q == PRIO_B));
    w_wr_xfer    = w_grant_a || w_grant_b;
    w_wr_dest    = w_grant_b ? wb.b_dest : wb.a_dest;
    w_wr_data    = w_grant_b ? wb.b_data : wb.a_data;

    w_rsv_ready  = !pending_q[wb.rsv_dest];
    w_rsv_xfer   = wb.rsv_valid && w_rsv_ready;

    w_set        = {{(NREG-1){1'b0}}, w_rsv_xfer} << wb.rsv_dest;
    w_clr        = {{(NREG-1){1'b0}}, w_wr_xfer}  << w_wr_dest;
    // Clear before set: an unreserved write racing a fresh reservation of the
    // same register must not wipe out the new reservation.
    pending_d    = (pending_q & ~w_clr) | w_set;
    w_unreserved = w_wr_xfer && !pending_q[w_wr_dest];

    prio_d = prio_q;
    if (w_grant_a) begin
      prio_d = PRIO_B;
    end else if (w_grant_b) begin
      prio_d = PRIO_A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q    <= PRIO_A;
      pending_q <= '0;
      rf_load_q <= 1'b0;
      rf_dest_q <= '0;
      rf_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      pending_q <= pending_d;
      rf_load_q <= w_wr_xfer;
      if (w_wr_xfer) begin
        rf_dest_q <= w_wr_dest;
        rf_data_q <= w_wr_data;
      end
      if (w_unreserved) begin
        err_q <= 1'b1;
      end
    end
  end

  assign wb.a_ready    = w_grant_a;
  assign wb.b_ready    = w_grant_b;
  assign wb.rsv_ready  = w_rsv_ready;
  assign wb.chk_busy_a = pending_q[wb.chk_src_a];
  assign wb.chk_busy_b = pending_q[wb.chk_src_b];
  assign wb.pending    = pending_q;
  assign wb.rf_load    = rf_load_q;
  assign wb.rf_dest    = rf_dest_q;
  assign wb.rf_data    = rf_data_q;
  assign wb.err        = err_q;

endmodule

`default_nettype wire
